// File: rtl/lot_gate_monitor.sv
// lot_gate_monitor
//   Counts vehicles through LANES independent two-beam gates. Each lane
//   decodes the order in which its outer (a) and inner (b) beams are
//   blocked and cleared; a complete a->ab->b->none pass is an entry, the
//   mirror b->ab->a->none pass is an exit. Occupancy is the saturating net
//   of all entries and exits in each cycle.
//
//   Optional feature: define LOT_GATE_INPUT_SYNC_EN to pass sens_a/sens_b
//   through 2-flop synchronisers, adding two cycles of latency.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset (release synchronised inside)
//   sens_a     outer beam per lane, 1 = blocked
//   sens_b     inner beam per lane, 1 = blocked
//   clr_err    synchronous clear of seq_err and ovf
//   entry_p    one-cycle pulse per completed entry, per lane
//   exit_p     one-cycle pulse per completed exit, per lane
//   occupancy  current vehicle count, saturating in [0, CAPACITY]
//   full       occupancy == CAPACITY (registered)
//   empty      occupancy == 0 (registered)
//   seq_err    sticky per-lane illegal-transition flag
//   ovf        sticky flag: saturation clipped an event
module lot_gate_monitor #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned CAPACITY = 100,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] sens_a,
  input  logic [LANES-1:0] sens_b,
  input  logic             clr_err,
  output logic [LANES-1:0] entry_p,
  output logic [LANES-1:0] exit_p,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] seq_err,
  output logic             ovf
);

  // Sum width leaves room for +/-8 events around any count value.
  localparam int unsigned SW = CNT_W + 5;

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  // Reset asserts immediately, releases two edges later.
  logic [1:0] rst_pipe;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n_int = rst_pipe[1];

  logic [LANES-1:0] sa, sb;

`ifdef LOT_GATE_INPUT_SYNC_EN
  logic [LANES-1:0] sa_meta, sb_meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_meta <= '0;
      sb_meta <= '0;
      sa      <= '0;
      sb      <= '0;
    end else begin
      sa_meta <= sens_a;
      sb_meta <= sens_b;
      sa      <= sa_meta;
      sb      <= sb_meta;
    end
  end
`else
  always_comb begin
    sa = sens_a;
    sb = sens_b;
  end
`endif

  state_t           state     [LANES];
  state_t           state_nxt [LANES];
  logic [LANES-1:0] ent_ev, ext_ev, err_ev;
  logic [1:0]       ab;

  always_comb begin
    ab     = '0;
    ent_ev = '0;
    ext_ev = '0;
    err_ev = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ab           = {sa[i], sb[i]};
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: case (ab)
          2'b10:   state_nxt[i] = EN1;
          2'b01:   state_nxt[i] = EX1;
          2'b11:   err_ev[i] = 1'b1;
          default: ;
        endcase
        EN1: case (ab)
          2'b11:   state_nxt[i] = EN2;
          2'b00:   state_nxt[i] = IDLE;
          2'b01:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EN2: case (ab)
          2'b01:   state_nxt[i] = EN3;
          2'b10:   state_nxt[i] = EN1;
          2'b00:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EN3: case (ab)
          2'b00:   begin state_nxt[i] = IDLE; ent_ev[i] = 1'b1; end
          2'b11:   state_nxt[i] = EN2;
          2'b10:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX1: case (ab)
          2'b11:   state_nxt[i] = EX2;
          2'b00:   state_nxt[i] = IDLE;
          2'b10:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX2: case (ab)
          2'b10:   state_nxt[i] = EX3;
          2'b01:   state_nxt[i] = EX1;
          2'b00:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX3: case (ab)
          2'b00:   begin state_nxt[i] = IDLE; ext_ev[i] = 1'b1; end
          2'b11:   state_nxt[i] = EX2;
          2'b01:   begin state_nxt[i] = IDLE; err_ev[i] = 1'b1; end
          default: ;
        endcase
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Entries and exits net first, then the result is clipped once.
  logic [3:0]           n_ent, n_ext;
  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0]     occ_nxt;
  logic                 clip;

  always_comb begin
    n_ent = '0;
    n_ext = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_ent = n_ent + 4'(ent_ev[i]);
      n_ext = n_ext + 4'(ext_ev[i]);
    end
    sum     = $signed(SW'(occupancy)) + $signed(SW'(n_ent)) - $signed(SW'(n_ext));
    clip    = 1'b0;
    occ_nxt = occupancy;
    if (sum[SW-1]) begin
      occ_nxt = '0;
      clip    = 1'b1;
    end else if (sum > $signed(SW'(CAPACITY))) begin
      occ_nxt = CNT_W'(CAPACITY);
      clip    = 1'b1;
    end else begin
      occ_nxt = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int unsigned i = 0; i < LANES; i++) state[i] <= IDLE;
      entry_p   <= '0;
      exit_p    <= '0;
      seq_err   <= '0;
      ovf       <= 1'b0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) state[i] <= state_nxt[i];
      entry_p   <= ent_ev;
      exit_p    <= ext_ev;
      // A new error in the clearing cycle wins over clr_err.
      seq_err   <= err_ev | (seq_err & ~{LANES{clr_err}});
      ovf       <= clip | (ovf & ~clr_err);
      occupancy <= occ_nxt;
      full      <= (occ_nxt == CNT_W'(CAPACITY));
      empty     <= (occ_nxt == '0);
    end
  end

endmodule

// File: tb/tb_lot_gate_monitor.sv
// tb_lot_gate_monitor
//   Scoreboard bench for lot_gate_monitor (LANES=2, CAPACITY=4). The driver
//   applies inputs on the falling edge and pushes the outputs the reference
//   model expects after the next rising edge; the monitor pops one record
//   per rising edge and compares all outputs. The reference model tracks
//   each lane as a position along an entry or exit path of beam patterns.
module tb_lot_gate_monitor;
  localparam int unsigned L   = 2;
  localparam int unsigned CAP = 4;
  localparam int unsigned W   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clr_err = 1'b0;
  logic [L-1:0] sens_a = '0, sens_b = '0;
  logic [L-1:0] entry_p, exit_p, seq_err;
  logic [W-1:0] occupancy;
  logic         full, empty, ovf;

  always #5 clk = ~clk;

  lot_gate_monitor #(.LANES(L), .CAPACITY(CAP), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .clr_err(clr_err), .entry_p(entry_p), .exit_p(exit_p),
    .occupancy(occupancy), .full(full), .empty(empty),
    .seq_err(seq_err), .ovf(ovf)
  );

  typedef struct {
    logic [L-1:0] ent, ext, err;
    int           occ;
    logic         full, empty, ovf;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int           pos [L];   // 0 = no vehicle, 1..3 = progress along path
  int           dir [L];   // 0 = entry path, 1 = exit path
  int           m_occ = 0;
  logic [L-1:0] m_err = '0;
  logic         m_ovf = 1'b0;
  int           rel = 0;   // edges seen since reset release
  logic [L-1:0] d1a = '0, d1b = '0, d2a = '0, d2b = '0;

  // Beam pattern {a,b} at position p of the entry (d=0) or exit (d=1) path.
  function automatic logic [1:0] pat(int d, int p);
    logic [1:0] r;
    case (p)
      0:       r = 2'b00;
      1:       r = (d == 0) ? 2'b10 : 2'b01;
      2:       r = 2'b11;
      default: r = (d == 0) ? 2'b01 : 2'b10;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic lane_step(input int i, input logic [1:0] ab,
                           output logic en, output logic ex, output logic er);
    en = 1'b0; ex = 1'b0; er = 1'b0;
    if (pos[i] == 0) begin
      if (ab == pat(0, 1)) begin dir[i] = 0; pos[i] = 1; end
      else if (ab == pat(1, 1)) begin dir[i] = 1; pos[i] = 1; end
      else if (ab == 2'b11) er = 1'b1;
    end else if (ab == pat(dir[i], pos[i])) begin
    end else if (ab == pat(dir[i], (pos[i] + 1) % 4)) begin
      if (pos[i] == 3) begin
        en = (dir[i] == 0);
        ex = (dir[i] == 1);
        pos[i] = 0;
      end else begin
        pos[i]++;
      end
    end else if (ab == pat(dir[i], pos[i] - 1)) begin
      pos[i]--;
    end else begin
      er = 1'b1;
      pos[i] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    exp_t         e;
    logic [L-1:0] ua, ub, ne_v, nx_v, nerr;
    logic         en, ex, er, ov;
    int           sum;
    ne_v = '0; nx_v = '0; nerr = '0;
    if (!reset) begin
      for (int i = 0; i < L; i++) pos[i] = 0;
      m_occ = 0; m_err = '0; m_ovf = 1'b0; rel = 0;
      d1a = '0; d1b = '0; d2a = '0; d2b = '0;
    end else begin
`ifdef LOT_GATE_INPUT_SYNC_EN
      ua = d2a; ub = d2b;
      d2a = d1a; d2b = d1b;
      d1a = sens_a; d1b = sens_b;
`else
      ua = sens_a; ub = sens_b;
`endif
      if (rel >= 2) begin
        sum = m_occ;
        for (int i = 0; i < L; i++) begin
          lane_step(i, {ua[i], ub[i]}, en, ex, er);
          ne_v[i] = en; nx_v[i] = ex; nerr[i] = er;
          sum = sum + int'(en) - int'(ex);
        end
        ov = 1'b0;
        if (sum > int'(CAP)) begin sum = CAP; ov = 1'b1; end
        else if (sum < 0) begin sum = 0; ov = 1'b1; end
        m_occ = sum;
        m_err = nerr | (clr_err ? '0 : m_err);
        m_ovf = ov | (clr_err ? 1'b0 : m_ovf);
      end
      if (rel < 2) rel++;
    end
    e.ent = ne_v; e.ext = nx_v; e.err = m_err; e.occ = m_occ;
    e.full = (m_occ == int'(CAP)); e.empty = (m_occ == 0); e.ovf = m_ovf;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [L-1:0] a, input logic [L-1:0] b,
                      input logic clr, input logic rst);
    @(negedge clk);
    sens_a = a; sens_b = b; clr_err = clr; reset = rst;
    if (!rst) begin
      #1;
      chk("occ_async_reset", int'(occupancy), 0);
      chk("entry_async_reset", int'(entry_p), 0);
    end
    model_edge();
  endtask

  task automatic entry0();
    step(2'b01, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic exit1();
    step(2'b00, 2'b10, 1'b0, 1'b1);
    step(2'b10, 2'b10, 1'b0, 1'b1);
    step(2'b10, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  // Monitor: one expected record per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("entry_p",   int'(entry_p),   int'(e.ent));
        chk("exit_p",    int'(exit_p),    int'(e.ext));
        chk("occupancy", int'(occupancy), e.occ);
        chk("full",      int'(full),      int'(e.full));
        chk("empty",     int'(empty),     int'(e.empty));
        chk("seq_err",   int'(seq_err),   int'(e.err));
        chk("ovf",       int'(ovf),       int'(e.ovf));
      end
    end
  end

  initial begin
    logic [L-1:0] ra, rb;
    logic [1:0]   ab;
    int           r;
    #1 reset = 1'b0;
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b1);

    // Basic entry, then up to three, then one exit on lane 1
    entry0();
    entry0();
    entry0();
    exit1();

    // Back-out on lane 0: no count, no error
    step(2'b01, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b01, 1'b0, 1'b1);
    step(2'b01, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);

    // Illegal 00->11 on lane 0, sticky until cleared; new error beats clear
    step(2'b01, 2'b01, 1'b0, 1'b1);
    step(2'b01, 2'b01, 1'b0, 1'b1);
    step(2'b01, 2'b01, 1'b1, 1'b1);
    step(2'b00, 2'b00, 1'b1, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);

    // Fill to capacity, clip one entry, then net entry+exit at full
    entry0();
    entry0();
    entry0();
    step(2'b00, 2'b00, 1'b1, 1'b1);
    step(2'b01, 2'b10, 1'b0, 1'b1);
    step(2'b11, 2'b11, 1'b0, 1'b1);
    step(2'b10, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);

    // Reset while lane 0 sits in the last entry phase
    step(2'b01, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0, 1'b1);

    // Randomised traffic biased toward plausible beam sequences
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < L; i++) begin
        r = int'($urandom_range(0, 99));
        if (pos[i] == 0)
          ab = (r < 50) ? pat(int'($urandom_range(0, 1)), 1)
                        : ((r < 92) ? 2'b00 : 2'($urandom()));
        else if (r < 40) ab = pat(dir[i], (pos[i] + 1) % 4);
        else if (r < 75) ab = pat(dir[i], pos[i]);
        else if (r < 92) ab = pat(dir[i], pos[i] - 1);
        else             ab = 2'($urandom());
        ra[i] = ab[1];
        rb[i] = ab[0];
      end
      step(ra, rb, ($urandom_range(0, 19) == 0), ($urandom_range(0, 249) != 0));
    end
    step('0, '0, 1'b0, 1'b1);

    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
